// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronizes and filters the pins, deframes 11-bit frames, keeps a 4-byte history.
// Optional odd-parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] data,
  output logic [7:0]  rx_byte,
  output logic        rx_done,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [3:0]    filt_cnt;
  logic          sample;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_bit_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic          commit, err;
  logic          parity_odd, par_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // filt_cnt counts consecutive cycles in which the synchronized clock disagrees with the filtered one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_filt <= 1'b1;
      filt_cnt <= 4'd0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= 4'd0;
    end else if (filt_cnt == 4'(FILTER_LEN - 1)) begin
      clk_filt <= clk_s2;
      filt_cnt <= 4'd0;
    end else begin
      filt_cnt <= filt_cnt + 4'd1;
    end
  end

  // Strobe in the cycle the filtered clock is about to fall, so the data bit is taken from the same cycle
  assign sample = clk_filt & ~clk_s2 & (filt_cnt == 4'(FILTER_LEN - 1));

  assign parity_odd = ^{shreg, par_bit};
`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = parity_odd;
`else
  assign par_ok = parity_odd | 1'b1;
`endif

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    tmo_cnt_n = tmo_cnt;
    commit    = 1'b0;
    err       = 1'b0;
    if (state == IDLE) begin
      tmo_cnt_n = '0;
      if (sample && !dat_s2) begin
        state_n   = DATA;
        bit_cnt_n = 3'd0;
      end
    end else if (sample) begin
      tmo_cnt_n = '0;
      case (state)
        DATA: begin
          shreg_n   = {dat_s2, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_bit_n = dat_s2;
          state_n   = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (dat_s2 && par_ok) commit = 1'b1;
          else                  err    = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n   = IDLE;
      tmo_cnt_n = '0;
      err       = 1'b1;
    end else begin
      tmo_cnt_n = tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par_bit <= par_bit_n;
      tmo_cnt <= tmo_cnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= 32'd0;
      rx_byte   <= 8'd0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= commit;
      frame_err <= err;
      if (commit) begin
        data    <= {data[23:0], shreg};
        rx_byte <= shreg;
      end
    end
  end

endmodule
